ha_serial_adder_seq: RTL and testbench

// - Sequencer that time-shares one external half-adder cell (tt_um_halfrahna datapath) to form a WIDTH-bit adder.
// - Adds bit-serially, LSB first, using two half-adder passes per bit: a^b, then partial^carry.
// - Operand and result transfers use valid/ready handshakes.
// - Sits between the pin-level wrapper (ui_in/uio_in operands, uo_out result) and the half-adder cell.

---
 rtl/ha_serial_adder_seq.sv | 119 +++++++++++
 tb/tb_ha_serial_adder_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ha_serial_adder_seq.sv
// rtl/ha_serial_adder_seq.sv - bit-serial WIDTH-bit adder sequencing one external half-adder cell
// Optional carry-out port and register enabled by defining HASEQ_COUT_EN.
module ha_serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef HASEQ_COUT_EN
  output logic             cout,
`endif
  output logic             ha_en,
  output logic             ha_a,
  output logic             ha_b,
  input  logic             ha_sum,
  input  logic             ha_carry
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IW-1:0]   idx;
  logic            phase;
  logic            c1;
  logic            carry;

  logic [IW-1:0]   idx_nxt;
  logic            carry_nxt;
  logic            last_bit;

  assign in_ready  = (state == IDLE);
  assign idx_nxt   = idx + IW'(1);
  assign carry_nxt = c1 | ha_carry;
  assign last_bit  = (idx == IW'(WIDTH - 1));

  // Sequencer: the cell operands are registered one step ahead, so the value the
  // cell sees in a cycle is loaded on the edge that enters that cycle. In phase 1
  // ha_a holds the partial sum a^b of the current bit (the "s1" of the algorithm).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      idx       <= '0;
      phase     <= 1'b0;
      c1        <= 1'b0;
      carry     <= 1'b0;
      sum       <= '0;
      out_valid <= 1'b0;
      ha_en     <= 1'b0;
      ha_a      <= 1'b0;
      ha_b      <= 1'b0;
`ifdef HASEQ_COUT_EN
      cout      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            idx   <= '0;
            phase <= 1'b0;
            carry <= 1'b0;
            sum   <= '0;
            ha_en <= 1'b1;
            ha_a  <= a[0];
            ha_b  <= b[0];
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!phase) begin
            c1    <= ha_carry;
            ha_a  <= ha_sum;
            ha_b  <= carry;
            phase <= 1'b1;
          end else begin
            sum[idx] <= ha_sum;
            carry    <= carry_nxt;
            phase    <= 1'b0;
            if (last_bit) begin
              state     <= DONE;
              out_valid <= 1'b1;
              ha_en     <= 1'b0;
              ha_a      <= 1'b0;
              ha_b      <= 1'b0;
`ifdef HASEQ_COUT_EN
              cout      <= carry_nxt;
`endif
            end else begin
              idx  <= idx_nxt;
              ha_a <= op_a[idx_nxt];
              ha_b <= op_b[idx_nxt];
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_serial_adder_seq.sv
// tb/tb_ha_serial_adder_seq.sv - randomized self-checking bench for ha_serial_adder_seq
module tb_ha_serial_adder_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
`ifdef HASEQ_COUT_EN
  logic         cout;
`endif
  logic         ha_en;
  logic         ha_a;
  logic         ha_b;
  logic         ha_sum;
  logic         ha_carry;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // External half-adder cell
  assign ha_sum   = ha_a ^ ha_b;
  assign ha_carry = ha_a & ha_b;

  ha_serial_adder_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef HASEQ_COUT_EN
    .cout      (cout),
`endif
    .ha_en     (ha_en),
    .ha_a      (ha_a),
    .ha_b      (ha_b),
    .ha_sum    (ha_sum),
    .ha_carry  (ha_carry)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation; called and returns at a negedge with the block idle.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input int hold);
    int ia, ib, tot, guard, cyc, en_cnt, k, cin;
    ia  = int'(xa);
    ib  = int'(xb);
    tot = ia + ib;
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("accept_ready", in_ready, 1);
    @(negedge clk);
    cyc = 1;
    // keep offering different operands; they must be ignored while busy
    a = ~xa; b = xb ^ 8'h5a;
    en_cnt = 0;
    while (!out_valid && cyc < 4 * W) begin
      if (ha_en) en_cnt++;
      k = (cyc - 1) / 2;
      if (k < W) begin
        if (cyc % 2 == 1) begin
          check_eq("ha_a_p0", ha_a, (ia >> k) & 1);
          check_eq("ha_b_p0", ha_b, (ib >> k) & 1);
        end else begin
          cin = ((ia % (1 << k)) + (ib % (1 << k))) >> k;
          check_eq("ha_a_p1", ha_a, ((ia ^ ib) >> k) & 1);
          check_eq("ha_b_p1", ha_b, cin);
        end
      end
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", cyc, 2 * W + 1);
    check_eq("ha_en_cycles", en_cnt, 2 * W);
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_ready", in_ready, 0);
      check_eq("hold_sum", sum, tot % 256);
`ifdef HASEQ_COUT_EN
      check_eq("hold_cout", cout, tot >> W);
`endif
      @(negedge clk);
    end
    check_eq("sum", sum, tot % 256);
`ifdef HASEQ_COUT_EN
    check_eq("cout", cout, tot >> W);
`endif
    check_eq("done_ha_en", ha_en, 0);
    check_eq("done_ha_ab", {ha_a, ha_b}, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("drop_valid", out_valid, 0);
    check_eq("idle_ready", in_ready, 1);
  endtask

  initial begin
    int e, nacc, guard;
    int acc_e[2];
    int hs_e[2];
    logic [W-1:0] res[$];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_ha", {ha_en, ha_a, ha_b}, 0);
`ifdef HASEQ_COUT_EN
    check_eq("rst_cout", cout, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h00, 8'h00, 0);
    run_op(8'hFF, 8'h01, 0);
    run_op(8'h5A, 8'h3C, 1);
    run_op(8'h80, 8'h80, 5);

    // Reset during bit 3 phase 0 of 0xAA+0x55
    a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("mid_busy", ha_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mrst_ready", in_ready, 1);
    check_eq("mrst_valid", out_valid, 0);
    check_eq("mrst_sum", sum, 0);
    check_eq("mrst_ha", {ha_en, ha_a, ha_b}, 0);
    run_op(8'h01, 8'h02, 0);

    // Back-to-back with in_valid and out_ready held high
    a = 8'h10; b = 8'h20; in_valid = 1'b1; out_ready = 1'b1;
    e = 0; nacc = 0; guard = 0;
    acc_e[0] = 0; acc_e[1] = 0; hs_e[0] = 0; hs_e[1] = 0;
    while (res.size() < 2 && guard < 200) begin
      if (nacc == 1) begin a = 8'h7F; b = 8'h01; end
      if (in_ready && in_valid && nacc < 2) begin
        acc_e[nacc] = e + 1;
        nacc++;
      end
      if (out_valid && out_ready) begin
        hs_e[res.size()] = e + 1;
        res.push_back(sum);
      end
      if (res.size() < 2) begin
        @(negedge clk);
        e++;
      end
      guard++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("b2b_count", res.size(), 2);
    if (res.size() == 2) begin
      check_eq("b2b_res0", res[0], 8'h30);
      check_eq("b2b_res1", res[1], 8'h80);
      check_eq("b2b_gap", acc_e[1] - hs_e[0], 1);
    end

    for (int i = 0; i < 12; i++) begin
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
